srot_tlul_responder: RTL
========================

# srot_tlul_responder

TileLink-UL (TL-UL) responder that terminates an A/D channel pair from the SROT TileLink fabric and converts each legal access into a single request on a simple register bus, with one transaction outstanding. It sits between the TL-UL host port and a block's register file. It checks each request, issues the register access, waits a bounded time for the acknowledge, and returns exactly one D-channel response per accepted A beat. Widths follow the SROT TileLink parameters: data 64, address 32, source 4, sink 2, size 3.

## Interface
Parameters:
- TimeoutCycles, 255: maximum register-bus wait, in cycles of reg_req high, before the access is aborted with an error; must be 1 to 1023.
- SinkId, 0: constant driven on d_sink.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- a_valid / a_ready  in / out  1 / 1  A-channel handshake.
- a_opcode  in  3  request opcode: 0 = PutFullData, 1 = PutPartialData, 4 = Get.
- a_param  in  3  ignored.
- a_size  in  3  log2 of bytes.
- a_source  in  4  requester ID.
- a_address  in  32  byte address.
- a_mask  in  8  byte lanes.
- a_data  in  64  write data.
- d_valid / d_ready  out / in  1 / 1  D-channel handshake.
- d_opcode  out  3  response opcode: 0 = AccessAck, 1 = AccessAckData.
- d_param  out  3  always 0.
- d_size  out  3  echoed a_size.
- d_source  out  4  echoed a_source.
- d_sink  out  2  SinkId.
- d_data  out  64  read data.
- d_error  out  1  error flag.
- reg_req  out  1  register access strobe, held until reg_ack or timeout.
- reg_we  out  1  1 = write.
- reg_addr  out  32  address with bits [2:0] cleared.
- reg_be  out  8  byte enables (a_mask).
- reg_wdata  out  64  write data.
- reg_rdata  in  64  read data, valid with reg_ack.
- reg_ack  in  1  access complete.
- reg_err  in  1  access failed, valid with reg_ack.

## Operation
- FSM states:
  - IDLE: a_ready = 1.
  - ACCESS: reg_req = 1.
  - RESP: d_valid = 1.
- IDLE, on a_valid: register opcode, size, source, address, mask and data, then run the legality checks.
- The request is illegal if any of these hold:
  - opcode not in {0, 1, 4};
  - a_size > 3;
  - address not aligned to 2^a_size;
  - a_mask is 0;
  - a_mask has bits outside the lanes addressed by a_address[2:0] and a_size;
  - for PutFullData, a_mask is not exactly those lanes.
- Illegal request: go to RESP with d_error = 1 and d_data = 0. No register access is made.
- Legal request: go to ACCESS. reg_we = (opcode != 4).
- ACCESS, on reg_ack:
  - capture reg_rdata, or 0 for writes, into d_data;
  - d_error = reg_err;
  - go to RESP.
- ACCESS, timeout: the counter counts cycles with reg_req high. When it reaches TimeoutCycles without reg_ack, drop reg_req, set d_error = 1 and d_data = 0, and go to RESP. A reg_ack arriving in that same cycle wins over the timeout.
- RESP: hold all d_* fields stable until d_ready, then go to IDLE.
- d_opcode = 1 for Get, 0 for puts, including error responses.
- Reset: state IDLE, a_ready = 1 (combinational from state), d_valid = 0, reg_req = 0, all other outputs 0. The counter clears to 0, and also clears on every entry to ACCESS.
- Reset asserted mid-transaction drops the transaction silently: no D response, reg_req low on the next cycle.

## Timing
- Cycle T, A handshake (a_valid & a_ready): reg_req = 1 in T+1 for a legal request; d_valid = 1 in T+1 for an illegal one.
- reg_ack in cycle T+1+k gives d_valid = 1 in T+2+k. Minimum A-to-D latency is 2 cycles.
- Timeout: reg_req is high for exactly TimeoutCycles cycles; d_valid asserts the next cycle.
- D handshake in cycle R gives a_ready = 1 in R+1. There is no back-to-back overlap.
- a_ready never depends on a_valid. d_valid never drops without d_ready.
- reg_* outputs are stable for the whole time reg_req is high.

## Test plan
- Legal read: Get, size 3, address 0x1000_0008, mask 0xFF, source 5; reg_ack with rdata 0xDEAD_BEEF_0123_4567 one cycle after reg_req -> reg_req at T+1 with reg_we = 0, d_valid at T+3, d_opcode 1, d_data 0xDEAD_BEEF_0123_4567, d_source 5, d_size 3, d_error 0.
- Partial write: PutPartialData, size 2, address 0x...4, mask 0x30, data 0x0000_AB00_0000_0000 -> reg_we 1, reg_be 0x30, reg_addr 0x...0, d_opcode 0, d_error 0.
- Illegal requests, each -> no reg_req, d_valid at T+1, d_error 1:
  - opcode 2;
  - PutFullData size 3 with mask 0x0F;
  - Get size 2 at address 0x2.
- Timeout: TimeoutCycles = 4, reg_ack never asserted -> reg_req high exactly 4 cycles, then d_error 1 and d_data 0; a reg_ack on the 4th cycle gives a normal response instead.
- Backpressure: d_ready held low for 10 cycles -> d_* fields stable and a_ready 0 throughout; a_ready = 1 the cycle after the handshake.
- Reset mid-ACCESS -> reg_req 0 and state IDLE next cycle, no D response; a subsequent Get completes normally.

Source files
------------

// File: rtl/srot_tlul_responder.sv
// TL-UL A/D responder for the SROT fabric: checks each A beat, runs one register-bus
// access with a bounded wait, and returns exactly one D response per accepted beat.
module srot_tlul_responder #(
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [1:0]  SinkId        = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [3:0]  a_source,
  input  logic [31:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [2:0]  d_param,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic [1:0]  d_sink,
  output logic [63:0] d_data,
  output logic        d_error,
  output logic        reg_req,
  output logic        reg_we,
  output logic [31:0] reg_addr,
  output logic [7:0]  reg_be,
  output logic [63:0] reg_wdata,
  input  logic [63:0] reg_rdata,
  input  logic        reg_ack,
  input  logic        reg_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  localparam logic [9:0] TIMEOUT_LAST = 10'(TimeoutCycles - 1);

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [2:0]  size_q;
  logic [3:0]  source_q;
  logic [31:3] addr_q;
  logic [7:0]  mask_q;
  logic [63:0] wdata_q;
  logic        we_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [9:0]  cnt;

  logic [7:0]  lanes_base;
  logic [7:0]  lanes;
  logic [2:0]  align_mask;
  logic        legal;
  logic        unused_param;

  assign unused_param = ^a_param;

  // Lanes a request may touch, derived from its size and byte offset in the 64-bit word.
  always_comb begin
    lanes_base = 8'h00;
    align_mask = 3'b000;
    case (a_size)
      3'd0: begin lanes_base = 8'h01; align_mask = 3'b000; end
      3'd1: begin lanes_base = 8'h03; align_mask = 3'b001; end
      3'd2: begin lanes_base = 8'h0F; align_mask = 3'b011; end
      3'd3: begin lanes_base = 8'hFF; align_mask = 3'b111; end
      default: begin lanes_base = 8'h00; align_mask = 3'b000; end
    endcase
    lanes = lanes_base << a_address[2:0];
    legal = (a_opcode == OP_PUT_FULL || a_opcode == OP_PUT_PART || a_opcode == OP_GET)
         && (a_size <= 3'd3)
         && ((a_address[2:0] & align_mask) == 3'b000)
         && (a_mask != 8'h00)
         && ((a_mask & ~lanes) == 8'h00)
         && (a_opcode != OP_PUT_FULL || a_mask == lanes);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= 3'd0;
      size_q   <= 3'd0;
      source_q <= 4'd0;
      addr_q   <= '0;
      mask_q   <= 8'h00;
      wdata_q  <= 64'd0;
      we_q     <= 1'b0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
      cnt      <= 10'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_valid) begin
            op_q     <= a_opcode;
            size_q   <= a_size;
            source_q <= a_source;
            addr_q   <= a_address[31:3];
            mask_q   <= a_mask;
            wdata_q  <= a_data;
            we_q     <= (a_opcode != OP_GET);
            cnt      <= 10'd0;
            if (legal) begin
              state <= ST_ACCESS;
            end else begin
              rdata_q <= 64'd0;
              err_q   <= 1'b1;
              state   <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          // An acknowledge in the final allowed cycle takes priority over the timeout.
          if (reg_ack) begin
            rdata_q <= we_q ? 64'd0 : reg_rdata;
            err_q   <= reg_err;
            state   <= ST_RESP;
          end else if (cnt == TIMEOUT_LAST) begin
            rdata_q <= 64'd0;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        ST_RESP: begin
          if (d_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign a_ready   = (state == ST_IDLE);
  assign reg_req   = (state == ST_ACCESS);
  assign reg_we    = reg_req & we_q;
  assign reg_addr  = {addr_q, 3'b000};
  assign reg_be    = mask_q;
  assign reg_wdata = wdata_q;

  assign d_valid  = (state == ST_RESP);
  assign d_opcode = (op_q == OP_GET) ? 3'd1 : 3'd0;
  assign d_param  = 3'd0;
  assign d_size   = size_q;
  assign d_source = source_q;
  assign d_sink   = SinkId;
  assign d_data   = rdata_q;
  assign d_error  = err_q;

endmodule
